// File: rtl/pipe_pkg.sv
// Shared pipeline-boundary types and limits.
// Common bit order for stage-boundary control bundles.
package pipe_pkg;

  localparam int PIPE_DEPTH_MAX = 4;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       jal;
    logic       sys;
    logic       brk;
    logic [2:0] spare;
  } mw_ctrl_t;

  localparam int PIPE_CTRL_W = $bits(mw_ctrl_t);
  localparam int PIPE_DATA_W = 160;

  function automatic logic [2:0] popcnt4(
    input logic [PIPE_DEPTH_MAX-1:0] v
  );
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < PIPE_DEPTH_MAX; i++)
      n = n + {2'b00, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One pipeline slot: async clear, hold, flush, shift-in.
// Ports: clk, rst_n, hold, flush, valid_in/ctrl_in/data_in, valid/ctrl/data.
module pipe_stage_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int DATA_W = PIPE_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (flush) begin
      // Bubble: kill valid and ctrl, keep the payload.
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (!hold) begin
      valid <= valid_in;
      ctrl  <= valid_in ? ctrl_in : '0;
      data  <= data_in;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised DEPTH-slot pipeline register with stall/flush.
// Ports: clk, rst_n, stall_i, flush_i, valid/ctrl/data in and out, occ_o;
// PIPE_STAGE_STATS_EN adds stall_cnt_o, flush_cnt_o (saturating).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int DATA_W = PIPE_DATA_W,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
`ifdef PIPE_STAGE_STATS_EN
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
`endif
  output logic [2:0]        occ_o
);

  if (DEPTH < 1 || DEPTH > PIPE_DEPTH_MAX) begin : g_bad_depth
    $error("pipe_stage_reg: DEPTH must be 1..4");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("pipe_stage_reg: CNT_W must be >= 1");
  end

  logic [DEPTH-1:0]  v;
  logic [CTRL_W-1:0] c [DEPTH];
  logic [DATA_W-1:0] d [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    logic              vin;
    logic [CTRL_W-1:0] cin;
    logic [DATA_W-1:0] din;
    if (k == 0) begin : g_head
      assign vin = valid_i;
      assign cin = ctrl_i;
      assign din = data_i;
    end else begin : g_tail
      assign vin = v[k-1];
      assign cin = c[k-1];
      assign din = d[k-1];
    end
    pipe_stage_slot #(
      .CTRL_W(CTRL_W),
      .DATA_W(DATA_W)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .hold    (stall_i),
      .flush   (flush_i),
      .valid_in(vin),
      .ctrl_in (cin),
      .data_in (din),
      .valid   (v[k]),
      .ctrl    (c[k]),
      .data    (d[k])
    );
  end

  assign valid_o = v[DEPTH-1];
  assign ctrl_o  = c[DEPTH-1];
  assign data_o  = d[DEPTH-1];

  logic [PIPE_DEPTH_MAX-1:0] vpad;
  always_comb begin
    vpad = '0;
    vpad[DEPTH-1:0] = v;
  end
  assign occ_o = popcnt4(vpad);

`ifdef PIPE_STAGE_STATS_EN
  logic stall_hit;
  assign stall_hit = stall_i & ~flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_hit && stall_cnt_o != '1)
        stall_cnt_o <= stall_cnt_o + 1'b1;
      if (flush_i && flush_cnt_o != '1)
        flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg.
// Three instances: DEPTH=1 (u1), DEPTH=2 (u2), DEPTH=3 (u3).
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         s1, f1, v1, s2, f2, v2, s3, f3, v3;
  logic [7:0]   c1, c2, c3;
  logic [159:0] d1, d2, d3;
  logic         vo1, vo2, vo3;
  logic [7:0]   co1, co2, co3;
  logic [159:0] do1, do2, do3;
  logic [2:0]   oc1, oc2, oc3;
`ifdef PIPE_STAGE_STATS_EN
  logic [3:0]   sc1, fc1, sc2, fc2, sc3, fc3;
`endif

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(160), .DEPTH(1), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .stall_i(s1), .flush_i(f1),
    .valid_i(v1), .ctrl_i(c1), .data_i(d1),
    .valid_o(vo1), .ctrl_o(co1), .data_o(do1),
`ifdef PIPE_STAGE_STATS_EN
    .stall_cnt_o(sc1), .flush_cnt_o(fc1),
`endif
    .occ_o(oc1));

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(160), .DEPTH(2), .CNT_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .stall_i(s2), .flush_i(f2),
    .valid_i(v2), .ctrl_i(c2), .data_i(d2),
    .valid_o(vo2), .ctrl_o(co2), .data_o(do2),
`ifdef PIPE_STAGE_STATS_EN
    .stall_cnt_o(sc2), .flush_cnt_o(fc2),
`endif
    .occ_o(oc2));

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(160), .DEPTH(3), .CNT_W(4)) u3 (
    .clk(clk), .rst_n(rst_n), .stall_i(s3), .flush_i(f3),
    .valid_i(v3), .ctrl_i(c3), .data_i(d3),
    .valid_o(vo3), .ctrl_o(co3), .data_o(do3),
`ifdef PIPE_STAGE_STATS_EN
    .stall_cnt_o(sc3), .flush_cnt_o(fc3),
`endif
    .occ_o(oc3));

  int errs = 0;
  int checks = 0;

  task automatic check(input string tag,
                       input logic [159:0] got,
                       input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic v,
                      input logic [7:0] c, input logic [159:0] d,
                      input logic [2:0] o);
    check({tag, ".v"}, 160'(vo1), 160'(v));
    check({tag, ".c"}, 160'(co1), 160'(c));
    check({tag, ".d"}, do1, d);
    check({tag, ".o"}, 160'(oc1), 160'(o));
  endtask

  initial begin
    {s1, f1, s2, f2, s3, f3} = '0;
    v1 = 1'b1; c1 = 8'hFF; d1 = 160'h1;
    v2 = 1'b1; c2 = 8'hFF; d2 = 160'h1;
    v3 = 1'b1; c3 = 8'hFF; d3 = 160'h1;

    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("rst", 1'b0, 8'h00, 160'h0, 3'd0);
    end
    check("rst.u2occ", 160'(oc2), 160'd0);
    check("rst.u3v", 160'(vo3), 160'd0);
    v1 = 1'b0; c1 = 8'h00; d1 = '0;
    v2 = 1'b0; c2 = 8'h00; d2 = '0;
    rst_n = 1'b1;

    // Latency and occupancy, DEPTH=3
    v3 = 1'b1; c3 = 8'h05; d3 = 160'hABCD;
    tick();
    check("lat.occ1", 160'(oc3), 160'd1);
    check("lat.v0", 160'(vo3), 160'd0);
    c3 = 8'h06; d3 = 160'h2;
    tick();
    check("lat.occ2", 160'(oc3), 160'd2);
    check("lat.v1", 160'(vo3), 160'd0);
    c3 = 8'h07; d3 = 160'h3;
    tick();
    check("lat.occ3", 160'(oc3), 160'd3);
    check("lat.v2", 160'(vo3), 160'd1);
    check("lat.c2", 160'(co3), 160'h05);
    check("lat.d2", do3, 160'hABCD);
    v3 = 1'b0; c3 = 8'h00; d3 = '0;
    tick();
    check("lat.c3", 160'(co3), 160'h06);
    check("lat.d3", do3, 160'h2);
    check("lat.occ4", 160'(oc3), 160'd2);

    // Stall, DEPTH=1
    v1 = 1'b1; c1 = 8'h05; d1 = 160'h1234;
    tick();
    chk1("ld", 1'b1, 8'h05, 160'h1234, 3'd1);
    s1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c1 = 8'h10 + 8'(i); d1 = 160'(32'hF000 + i);
      tick();
      chk1("stall", 1'b1, 8'h05, 160'h1234, 3'd1);
    end
`ifdef PIPE_STAGE_STATS_EN
    check("stall.cnt4", 160'(sc1), 160'd4);
`endif
    s1 = 1'b0; c1 = 8'h09; d1 = 160'h5678;
    tick();
    chk1("unstall", 1'b1, 8'h09, 160'h5678, 3'd1);

    // Flush with stall, DEPTH=2
    v2 = 1'b1; c2 = 8'h0A; d2 = 160'hAA;
    tick();
    c2 = 8'h0B; d2 = 160'hBB;
    tick();
    check("fl.pre.c", 160'(co2), 160'h0A);
    check("fl.pre.occ", 160'(oc2), 160'd2);
    s2 = 1'b1; f2 = 1'b1; c2 = 8'h0C; d2 = 160'hCC;
    tick();
    check("fl.v", 160'(vo2), 160'd0);
    check("fl.c", 160'(co2), 160'd0);
    check("fl.occ", 160'(oc2), 160'd0);
    check("fl.d", do2, 160'hAA);
    s2 = 1'b0; f2 = 1'b0; c2 = 8'h0D; d2 = 160'hDD;
    tick();
    check("fl.post.v", 160'(vo2), 160'd0);
    check("fl.post.d", do2, 160'hBB);
    check("fl.post.occ", 160'(oc2), 160'd1);

    // Bubble masking
    v1 = 1'b0; c1 = 8'h01; d1 = 160'h77;
    tick();
    chk1("bub", 1'b0, 8'h00, 160'h77, 3'd0);

    // Flush counting; stall alongside flush is not a stall
    s1 = 1'b1; f1 = 1'b1;
    tick();
`ifdef PIPE_STAGE_STATS_EN
    check("fcnt", 160'(fc1), 160'd1);
    check("scnt.fl", 160'(sc1), 160'd4);
`endif
    s1 = 1'b0; f1 = 1'b0;
    v1 = 1'b1; c1 = 8'h33; d1 = 160'h99;
    tick();
    chk1("ld2", 1'b1, 8'h33, 160'h99, 3'd1);

    // Long stall then async reset mid-cycle
    s1 = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk1("lstall", 1'b1, 8'h33, 160'h99, 3'd1);
`ifdef PIPE_STAGE_STATS_EN
    check("scnt.sat", 160'(sc1), 160'hF);
`endif
    #3 rst_n = 1'b0;
    #1;
    chk1("arst", 1'b0, 8'h00, 160'h0, 3'd0);
`ifdef PIPE_STAGE_STATS_EN
    check("arst.sc", 160'(sc1), 160'd0);
    check("arst.fc", 160'(fc1), 160'd0);
`endif
    #1 rst_n = 1'b1;
    s1 = 1'b0;
    tick();
    chk1("post", 1'b1, 8'h33, 160'h99, 3'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
